// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter that serialises fetch (port 0) and load/store (port 1)
// requests onto a single-port memory; every output is driven straight from a flop.
module mem_arbiter #(
    parameter int DATA_WIDTH  = 32,
    parameter int DATA_SIZE   = 1024,
    parameter int WAIT_CYCLES = 0
) (
    input  logic                  clk_in,
    input  logic                  rst_n_in,
    input  logic                  p0_req,
    input  logic                  p1_req,
    input  logic                  p0_write,
    input  logic                  p1_write,
    input  logic [DATA_WIDTH-1:0] p0_addr,
    input  logic [DATA_WIDTH-1:0] p1_addr,
    input  logic [DATA_WIDTH-1:0] p0_wdata,
    input  logic [DATA_WIDTH-1:0] p1_wdata,
    output logic [DATA_WIDTH-1:0] p0_rdata,
    output logic [DATA_WIDTH-1:0] p1_rdata,
    output logic                  p0_ack,
    output logic                  p1_ack,
    output logic                  p0_err,
    output logic                  p1_err,
    output logic                  mem_enable,
    output logic                  mem_write,
    output logic [DATA_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_ready
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    localparam logic [DATA_WIDTH-1:0] ADDR_LIMIT = DATA_WIDTH'(DATA_SIZE);
    localparam logic [3:0]            WAIT_LOAD  = 4'(WAIT_CYCLES);

    state_t                state, state_nxt;
    logic                  last_grant, last_grant_nxt;
    logic                  grant_port, grant_port_nxt;
    logic                  lat_write, lat_write_nxt;
    logic [3:0]            wait_cnt, wait_cnt_nxt;
    logic                  mem_enable_nxt, mem_write_nxt;
    logic [DATA_WIDTH-1:0] mem_addr_nxt, mem_wdata_nxt;
    logic [DATA_WIDTH-1:0] p0_rdata_nxt, p1_rdata_nxt;
    logic                  p0_ack_nxt, p1_ack_nxt, p0_err_nxt, p1_err_nxt;
    logic                  pick;
    logic                  sel_write;
    logic [DATA_WIDTH-1:0] sel_addr, sel_wdata;

    always_comb begin
        state_nxt      = state;
        last_grant_nxt = last_grant;
        grant_port_nxt = grant_port;
        lat_write_nxt  = lat_write;
        wait_cnt_nxt   = wait_cnt;
        mem_enable_nxt = 1'b0;
        mem_write_nxt  = 1'b0;
        mem_addr_nxt   = mem_addr;
        mem_wdata_nxt  = mem_wdata;
        p0_rdata_nxt   = p0_rdata;
        p1_rdata_nxt   = p1_rdata;
        p0_ack_nxt     = 1'b0;
        p1_ack_nxt     = 1'b0;
        p0_err_nxt     = 1'b0;
        p1_err_nxt     = 1'b0;
        // On a tie the port that did not win last time gets the bus.
        pick      = (p0_req && p1_req) ? ~last_grant : p1_req;
        sel_write = pick ? p1_write : p0_write;
        sel_addr  = pick ? p1_addr  : p0_addr;
        sel_wdata = pick ? p1_wdata : p0_wdata;

        case (state)
            IDLE: begin
                if (p0_req || p1_req) begin
                    grant_port_nxt = pick;
                    last_grant_nxt = pick;
                    lat_write_nxt  = sel_write;
                    mem_addr_nxt   = sel_addr;
                    mem_wdata_nxt  = sel_wdata;
                    if (sel_addr < ADDR_LIMIT) begin
                        state_nxt      = ACCESS;
                        wait_cnt_nxt   = WAIT_LOAD;
                        mem_enable_nxt = 1'b1;
                        mem_write_nxt  = sel_write && (WAIT_LOAD == 4'd0);
                    end else begin
                        // Out-of-range: answer straight away, memory is never touched.
                        state_nxt  = RESP;
                        p0_ack_nxt = ~pick;
                        p1_ack_nxt = pick;
                        p0_err_nxt = ~pick;
                        p1_err_nxt = pick;
                    end
                end
            end
            ACCESS: begin
                if (wait_cnt != 4'd0) begin
                    wait_cnt_nxt   = wait_cnt - 4'd1;
                    mem_enable_nxt = 1'b1;
                    mem_write_nxt  = lat_write && (wait_cnt == 4'd1);
                end else if (mem_ready) begin
                    state_nxt = RESP;
                    if (!lat_write) begin
                        if (grant_port) p1_rdata_nxt = mem_rdata;
                        else            p0_rdata_nxt = mem_rdata;
                    end
                    p0_ack_nxt = ~grant_port;
                    p1_ack_nxt = grant_port;
                end else begin
                    mem_enable_nxt = 1'b1;
                    mem_write_nxt  = lat_write;
                end
            end
            RESP: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            grant_port <= 1'b0;
            lat_write  <= 1'b0;
            wait_cnt   <= '0;
            mem_enable <= 1'b0;
            mem_write  <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            p0_rdata   <= '0;
            p1_rdata   <= '0;
            p0_ack     <= 1'b0;
            p1_ack     <= 1'b0;
            p0_err     <= 1'b0;
            p1_err     <= 1'b0;
        end else begin
            state      <= state_nxt;
            last_grant <= last_grant_nxt;
            grant_port <= grant_port_nxt;
            lat_write  <= lat_write_nxt;
            wait_cnt   <= wait_cnt_nxt;
            mem_enable <= mem_enable_nxt;
            mem_write  <= mem_write_nxt;
            mem_addr   <= mem_addr_nxt;
            mem_wdata  <= mem_wdata_nxt;
            p0_rdata   <= p0_rdata_nxt;
            p1_rdata   <= p1_rdata_nxt;
            p0_ack     <= p0_ack_nxt;
            p1_ack     <= p1_ack_nxt;
            p0_err     <= p0_err_nxt;
            p1_err     <= p1_err_nxt;
        end
    end

endmodule
